// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode, field and width constants for the alu
package alu_pkg;

  localparam int WIDTH = 32;
  localparam int OP_LO = 24;
  localparam int OP_HI = 27;
  localparam int S_BIT = 28;

  typedef enum logic [3:0] {
    OP_ADD   = 4'h0,
    OP_SUB   = 4'h1,
    OP_AND   = 4'h2,
    OP_OR    = 4'h3,
    OP_XOR   = 4'h4,
    OP_NOR   = 4'h5,
    OP_LSL   = 4'h6,
    OP_LSR   = 4'h7,
    OP_ASR   = 4'h8,
    OP_NEG   = 4'h9,
    OP_ADC   = 4'hA,
    OP_SBC   = 4'hB,
    OP_MOV   = 4'hC,
    OP_MVN   = 4'hD,
    OP_ROR   = 4'hE,
    OP_PASSA = 4'hF
  } op_t;

  localparam logic [1:0] SH_LSL = 2'd0;
  localparam logic [1:0] SH_LSR = 2'd1;
  localparam logic [1:0] SH_ASR = 2'd2;
  localparam logic [1:0] SH_ROR = 2'd3;

endpackage

// File: rtl/alu_shifter.sv
// rtl/alu_shifter.sv - combinational LSL/LSR/ASR/ROR with last-bit-out carry
module alu_shifter
  import alu_pkg::*;
(
  input  logic [WIDTH-1:0] value,
  input  logic [4:0]       amount,
  input  logic [1:0]       sh_type,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             cvalid
);

  always_comb begin
    result = value;
    cout   = 1'b0;
    cvalid = (amount != 5'd0);
    // An extra bit beside the word catches the last bit shifted out.
    case (sh_type)
      SH_LSL: {cout, result} = {1'b0, value} << amount;
      SH_LSR: {result, cout} = {value, 1'b0} >> amount;
      SH_ASR: {result, cout} = $signed({value, 1'b0}) >>> amount;
      SH_ROR: begin
        result = (value >> amount) | (value << (6'd32 - {1'b0, amount}));
        cout   = result[WIDTH-1];
      end
      default: begin
        result = value;
        cout   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu.sv
// rtl/alu.sv - 32-bit registered ALU with N/Z/C/V flags, one-cycle latency
module alu
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] d,
  input  logic [31:0] inf,
  output logic [31:0] r,
  output logic        n,
  output logic        z,
  output logic        c,
  output logic        v
);

  logic [3:0]       op;
  logic             s_en;
  logic             unused_inf;
  logic [WIDTH-1:0] add_x;
  logic [WIDTH-1:0] add_y;
  logic             add_cin;
  logic [WIDTH:0]   sum;
  logic             add_v;
  logic [1:0]       sh_type;
  logic [WIDTH-1:0] sh_result;
  logic             sh_cout;
  logic             sh_cvalid;
  logic [WIDTH-1:0] res;
  logic             c_nxt;
  logic             v_nxt;

  assign op         = inf[OP_HI:OP_LO];
  assign s_en       = inf[S_BIT];
  assign unused_inf = ^{inf[31:29], inf[23:0]};

  // Subtraction is a + ~b + carry-in, so carry out is ARM's NOT-borrow.
  always_comb begin
    add_x   = a;
    add_y   = d;
    add_cin = 1'b0;
    case (op)
      OP_ADC: add_cin = c;
      OP_SUB: begin
        add_y   = ~d;
        add_cin = 1'b1;
      end
      OP_SBC: begin
        add_y   = ~d;
        add_cin = c;
      end
      OP_NEG: begin
        add_x   = '0;
        add_y   = ~d;
        add_cin = 1'b1;
      end
      default: ;
    endcase
  end

  assign sum   = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_cin};
  assign add_v = (add_x[WIDTH-1] == add_y[WIDTH-1]) && (sum[WIDTH-1] != add_x[WIDTH-1]);

  always_comb begin
    case (op)
      OP_LSL:  sh_type = SH_LSL;
      OP_LSR:  sh_type = SH_LSR;
      OP_ASR:  sh_type = SH_ASR;
      default: sh_type = SH_ROR;
    endcase
  end

  alu_shifter u_shifter (
    .value   (a),
    .amount  (d[4:0]),
    .sh_type (sh_type),
    .result  (sh_result),
    .cout    (sh_cout),
    .cvalid  (sh_cvalid)
  );

  always_comb begin
    res   = a;
    c_nxt = c;
    v_nxt = v;
    case (op)
      OP_ADD, OP_SUB, OP_NEG, OP_ADC, OP_SBC: begin
        res   = sum[WIDTH-1:0];
        c_nxt = sum[WIDTH];
        v_nxt = add_v;
      end
      OP_AND:   res = a & d;
      OP_OR:    res = a | d;
      OP_XOR:   res = a ^ d;
      OP_NOR:   res = ~(a | d);
      OP_LSL, OP_LSR, OP_ASR, OP_ROR: begin
        res = sh_result;
        if (sh_cvalid) c_nxt = sh_cout;
      end
      OP_MOV:   res = d;
      OP_MVN:   res = ~d;
      OP_PASSA: res = a;
      default:  res = a;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r <= '0;
      n <= 1'b0;
      z <= 1'b0;
      c <= 1'b0;
      v <= 1'b0;
    end else begin
      r <= res;
      if (s_en) begin
        n <= res[WIDTH-1];
        z <= (res == '0);
        c <= c_nxt;
        v <= v_nxt;
      end
    end
  end

endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - directed self-checking bench for alu
module tb_alu;

  logic        clk;
  logic        rst;
  logic [31:0] a;
  logic [31:0] d;
  logic [31:0] inf;
  logic [31:0] r;
  logic        n;
  logic        z;
  logic        c;
  logic        v;

  int n_checks = 0;
  int n_pass   = 0;

  alu dut (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .d   (d),
    .inf (inf),
    .r   (r),
    .n   (n),
    .z   (z),
    .c   (c),
    .v   (v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Present one operation, clock it, sample 1 time unit after the edge.
  task automatic step(input logic [3:0] op, input logic s, input logic [31:0] va, input logic [31:0] vd);
    a   = va;
    d   = vd;
    inf = 32'hE000_0000 | ({31'd0, s} << 28) | ({28'd0, op} << 24);
    @(posedge clk);
    #1;
  endtask

  task automatic vec(input string tag, input logic [3:0] op, input logic s,
                     input logic [31:0] va, input logic [31:0] vd,
                     input logic [31:0] exp_r, input logic [3:0] exp_nzcv);
    step(op, s, va, vd);
    check({tag, ".r"}, r, exp_r);
    check({tag, ".nzcv"}, {28'd0, n, z, c, v}, {28'd0, exp_nzcv});
  endtask

  logic [31:0] sweep_exp [16];

  initial begin
    rst = 1'b1;
    a = 32'h1234_5678;
    d = 32'h0000_0007;
    inf = 32'h1000_0000;
    @(posedge clk);
    step(4'h0, 1'b1, 32'h8000_0000, 32'h8000_0000);
    step(4'h0, 1'b1, 32'h8000_0000, 32'h8000_0000);
    check("reset.r", r, 32'h0);
    check("reset.nzcv", {28'd0, n, z, c, v}, 32'h0);
    rst = 1'b0;

    vec("add_2_2",     4'h0, 1'b1, 32'd2,         32'd2,         32'd4,         4'b0000);
    vec("add_ovf",     4'h0, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h0,         4'b0111);
    vec("sub_eq",      4'h1, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h0,         4'b0110);
    vec("and_hold",    4'h2, 1'b0, 32'd1,         32'd1,         32'd1,         4'b0110);
    vec("sub_borrow",  4'h1, 1'b1, 32'd1,         32'd3,         32'hFFFF_FFFE, 4'b1000);
    vec("neg_min",     4'h9, 1'b1, 32'd0,         32'h8000_0000, 32'h8000_0000, 4'b1001);
    vec("neg_zero",    4'h9, 1'b1, 32'd0,         32'd0,         32'h0,         4'b0110);
    vec("lsl_1",       4'h6, 1'b1, 32'h8000_0001, 32'd1,         32'd2,         4'b0010);
    vec("ror_1",       4'hE, 1'b1, 32'h8000_0001, 32'd1,         32'hC000_0000, 4'b1010);
    vec("adc_wrap",    4'hA, 1'b1, 32'hFFFF_FFFF, 32'd0,         32'h0,         4'b0110);
    vec("lsr_amt0",    4'h7, 1'b1, 32'd2,         32'd32,        32'd2,         4'b0010);
    vec("adc_chain1",  4'hA, 1'b1, 32'hFFFF_FFFF, 32'd1,         32'd1,         4'b0010);
    vec("adc_chain2",  4'hA, 1'b1, 32'd0,         32'd0,         32'd1,         4'b0000);
    vec("asr_neg",     4'h8, 1'b1, 32'h8000_0000, 32'd4,         32'hF800_0000, 4'b1000);
    vec("set_c",       4'h1, 1'b1, 32'd5,         32'd3,         32'd2,         4'b0010);

    rst = 1'b1;
    step(4'hA, 1'b1, 32'd7, 32'd7);
    check("midrst.r", r, 32'h0);
    check("midrst.nzcv", {28'd0, n, z, c, v}, 32'h0);
    rst = 1'b0;
    vec("adc_postrst", 4'hA, 1'b1, 32'd5, 32'd5, 32'd10, 4'b0000);

    sweep_exp = '{32'd6, 32'd2, 32'd0, 32'd6, 32'd6, 32'hFFFF_FFF9, 32'd16, 32'd1,
                  32'd1, 32'hFFFF_FFFE, 32'd6, 32'd1, 32'd2, 32'hFFFF_FFFD, 32'd1, 32'd4};
    for (int i = 0; i < 16; i++) begin
      step(i[3:0], 1'b0, 32'd4, 32'd2);
      check($sformatf("sweep_c0_op%0h", i), r, sweep_exp[i]);
    end
    check("sweep_c0.nzcv", {28'd0, n, z, c, v}, 32'h0);

    vec("set_c2",      4'h1, 1'b1, 32'd5, 32'd3, 32'd2, 4'b0010);
    vec("adc_c1",      4'hA, 1'b0, 32'd4, 32'd2, 32'd7, 4'b0010);
    vec("sbc_c1",      4'hB, 1'b0, 32'd4, 32'd2, 32'd2, 4'b0010);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
